// File: rtl/multdiv_ctrl.sv
// Sequencing controller for an iterative multiplier/divider pair: start pulses, per-iteration enables,
// result capture and a one-cycle ready strobe. Define DIV_ZERO_EARLY_EN to short-circuit divide-by-zero.
module multdiv_ctrl #(
  parameter int MULT_CYCLES = 16,
  parameter int DIV_CYCLES  = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandB,
  input  logic [31:0] mult_result,
  input  logic        mult_exception,
  input  logic [31:0] div_result,
  input  logic        div_exception,
  output logic        mult_start,
  output logic        div_start,
  output logic        mult_enable,
  output logic        div_enable,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RUN, CAPTURE, DONE} state_t;

  localparam logic [5:0] MULT_LAST = 6'(MULT_CYCLES - 1);
  localparam logic [5:0] DIV_LAST  = 6'(DIV_CYCLES - 1);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        op_q, op_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;
  logic        rdy_q, rdy_d;
  logic        busy_q, busy_d;
  logic        men_q, men_d;
  logic        den_q, den_d;
  logic        start;

`ifdef DIV_ZERO_EARLY_EN
  logic        dz_q, dz_d;
`else
  logic        unused_b;
  assign unused_b = ^data_operandB;
`endif

  assign start      = ctrl_MULT | ctrl_DIV;
  assign mult_start = ctrl_MULT;
  assign div_start  = ctrl_DIV & ~ctrl_MULT;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    result_d = result_q;
    exc_d    = exc_q;
`ifdef DIV_ZERO_EARLY_EN
    dz_d     = dz_q;
`endif
    case (state_q)
      RUN: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == (op_q ? DIV_LAST : MULT_LAST)) state_d = CAPTURE;
      end
      CAPTURE: begin
        state_d  = DONE;
        result_d = op_q ? div_result : mult_result;
        exc_d    = op_q ? div_exception : mult_exception;
`ifdef DIV_ZERO_EARLY_EN
        if (dz_q) begin
          result_d = 32'h0;
          exc_d    = 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = state_q;
    endcase
    // A new request overrides everything, including a capture that would land this cycle.
    if (start) begin
      state_d  = RUN;
      cnt_d    = 6'd0;
      op_d     = ~ctrl_MULT;
      result_d = result_q;
      exc_d    = exc_q;
`ifdef DIV_ZERO_EARLY_EN
      dz_d = ~ctrl_MULT & (data_operandB == 32'h0);
      if (dz_d) state_d = CAPTURE;
`endif
    end
    busy_d = (state_d == RUN) || (state_d == CAPTURE);
    men_d  = (state_d == RUN) && !op_d;
    den_d  = (state_d == RUN) && op_d;
    rdy_d  = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      op_q     <= 1'b0;
      result_q <= 32'h0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
      men_q    <= 1'b0;
      den_q    <= 1'b0;
`ifdef DIV_ZERO_EARLY_EN
      dz_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
      men_q    <= men_d;
      den_q    <= den_d;
`ifdef DIV_ZERO_EARLY_EN
      dz_q     <= dz_d;
`endif
    end
  end

  assign mult_enable    = men_q;
  assign div_enable     = den_q;
  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: cycle 0 is the cycle carrying the start pulse; traces enables,
// busy and ready per cycle and compares them against hand-computed cycle numbers.
module tb_multdiv_ctrl;
  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandB, mult_result, div_result;
  logic        mult_exception, div_exception;
  logic        mult_start, div_start, mult_enable, div_enable;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;

  int checks = 0;
  int failures = 0;
  int rdy_first, rdy_cnt, men_cnt, men_first, men_last, den_cnt, den_first, den_last, busy_cnt;

  multdiv_ctrl dut (
    .clock(clock), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandB(data_operandB), .mult_result(mult_result), .mult_exception(mult_exception),
    .div_result(div_result), .div_exception(div_exception), .mult_start(mult_start),
    .div_start(div_start), .mult_enable(mult_enable), .div_enable(div_enable),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ev_kind: 0 none, 1 ctrl_DIV pulse, 2 reset, 3 ctrl_MULT pulse -- applied during cycle ev_cyc.
  task automatic run(input logic m, input logic d, input logic [31:0] b,
                     input int ev_cyc, input int ev_kind, input int ncyc);
    rdy_first = -1; rdy_cnt = 0; busy_cnt = 0;
    men_cnt = 0; men_first = -1; men_last = -1;
    den_cnt = 0; den_first = -1; den_last = -1;
    ctrl_MULT = m; ctrl_DIV = d; data_operandB = b;
    #1;
    chk("mult_start_c0", {31'd0, mult_start}, {31'd0, m});
    chk("div_start_c0", {31'd0, div_start}, {31'd0, d & ~m});
    tick();
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      if (data_resultRDY) begin rdy_cnt++; if (rdy_first < 0) rdy_first = k; end
      if (busy) busy_cnt++;
      if (mult_enable) begin men_cnt++; if (men_first < 0) men_first = k; men_last = k; end
      if (div_enable) begin den_cnt++; if (den_first < 0) den_first = k; den_last = k; end
      if (ev_kind == 2 && k == ev_cyc + 1)
        chk("outs_after_reset", {data_result, 3'd0, data_exception, data_resultRDY, busy, mult_enable, div_enable}, 40'd0);
      if (k == ev_cyc) begin
        if (ev_kind == 1) ctrl_DIV = 1'b1;
        if (ev_kind == 2) reset = 1'b1;
        if (ev_kind == 3) ctrl_MULT = 1'b1;
      end
      tick();
      ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; reset = 1'b0;
    end
    $display("run m=%0d d=%0d b=%0h ev=%0d@%0d: rdy@%0d x%0d men=%0d[%0d..%0d] den=%0d[%0d..%0d] busy=%0d res=%0h exc=%0d",
             m, d, b, ev_kind, ev_cyc, rdy_first, rdy_cnt, men_cnt, men_first, men_last,
             den_cnt, den_first, den_last, busy_cnt, data_result, data_exception);
  endtask

  initial begin
    reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; data_operandB = 32'h0;
    mult_result = 32'h0; mult_exception = 1'b0; div_result = 32'h0; div_exception = 1'b0;
    repeat (2) tick();
    chk("reset_outs", {data_result, 3'd0, data_exception, data_resultRDY, busy, mult_enable, div_enable}, 40'd0);
    // Start pulse while reset is high must be ignored.
    ctrl_MULT = 1'b1;
    #1;
    chk("mult_start_in_reset", {31'd0, mult_start}, 32'd1);
    tick();
    ctrl_MULT = 1'b0; reset = 1'b0;
    chk("reset_prio_busy", {31'd0, busy}, 32'd0);
    chk("reset_prio_men", {31'd0, mult_enable}, 32'd0);
    tick();
    chk("reset_prio_busy2", {31'd0, busy}, 32'd0);

    // Multiply: enables cycles 1..16, RDY at 18.
    mult_result = 32'd42; mult_exception = 1'b0;
    run(1'b1, 1'b0, 32'd0, -1, 0, 20);
    chk("mul_men_cnt", men_cnt, 16); chk("mul_men_first", men_first, 1); chk("mul_men_last", men_last, 16);
    chk("mul_den_cnt", den_cnt, 0); chk("mul_busy_cnt", busy_cnt, 17);
    chk("mul_rdy_first", rdy_first, 18); chk("mul_rdy_cnt", rdy_cnt, 1);
    chk("mul_result", data_result, 32'd42); chk("mul_exc", {31'd0, data_exception}, 32'd0);
    mult_result = 32'd99;
    repeat (3) tick();
    chk("mul_hold", data_result, 32'd42);

    // Divide: enables cycles 1..32, RDY at 34.
    div_result = 32'd5; div_exception = 1'b0;
    run(1'b0, 1'b1, 32'd7, -1, 0, 36);
    chk("div_den_cnt", den_cnt, 32); chk("div_den_first", den_first, 1); chk("div_den_last", den_last, 32);
    chk("div_men_cnt", men_cnt, 0); chk("div_rdy_first", rdy_first, 34); chk("div_rdy_cnt", rdy_cnt, 1);
    chk("div_result", data_result, 32'd5);

    // Simultaneous start: multiply wins.
    mult_result = 32'd77; div_result = 32'd55;
    run(1'b1, 1'b1, 32'd3, -1, 0, 20);
    chk("sim_men_cnt", men_cnt, 16); chk("sim_den_cnt", den_cnt, 0);
    chk("sim_rdy_first", rdy_first, 18); chk("sim_result", data_result, 32'd77);

    // Multiply aborted by divide in cycle 5: RDY at 39 with div result.
    mult_result = 32'd11; div_result = 32'd9;
    run(1'b1, 1'b0, 32'd7, 5, 1, 42);
    chk("abort_men_cnt", men_cnt, 5); chk("abort_den_first", den_first, 6); chk("abort_den_last", den_last, 37);
    chk("abort_rdy_first", rdy_first, 39); chk("abort_rdy_cnt", rdy_cnt, 1); chk("abort_result", data_result, 32'd9);

    // Abort during CAPTURE (cycle 17): no capture of the multiply, RDY at 51.
    mult_result = 32'd123; div_result = 32'd321;
    run(1'b1, 1'b0, 32'd7, 17, 1, 53);
    chk("capabort_rdy_first", rdy_first, 51); chk("capabort_rdy_cnt", rdy_cnt, 1);
    chk("capabort_result", data_result, 32'd321);

    // Start during DONE: RDY at 18 still, new op RDY at 36.
    mult_result = 32'd66;
    run(1'b1, 1'b0, 32'd0, 18, 3, 40);
    chk("done_rdy_first", rdy_first, 18); chk("done_rdy_cnt", rdy_cnt, 2); chk("done_men_cnt", men_cnt, 32);

    // Reset in cycle 8 of a multiply.
    mult_result = 32'd500;
    run(1'b1, 1'b0, 32'd0, 8, 2, 25);
    chk("rst_men_cnt", men_cnt, 8); chk("rst_rdy_cnt", rdy_cnt, 0); chk("rst_result", data_result, 32'd0);

    // Divide by zero.
    div_result = 32'hDEAD; div_exception = 1'b1;
    run(1'b0, 1'b1, 32'd0, -1, 0, 36);
`ifdef DIV_ZERO_EARLY_EN
    chk("dz_rdy_first", rdy_first, 2); chk("dz_den_cnt", den_cnt, 0);
    chk("dz_result", data_result, 32'd0); chk("dz_exc", {31'd0, data_exception}, 32'd1);
`else
    chk("dz_rdy_first", rdy_first, 34); chk("dz_den_cnt", den_cnt, 32);
    chk("dz_result", data_result, 32'hDEAD); chk("dz_exc", {31'd0, data_exception}, 32'd1);
`endif
    chk("dz_rdy_cnt", rdy_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
